// File: rtl/line_fill_ram.sv
// ============================================================================
// Module   : line_fill_ram
// Purpose  : Byte-addressed backing memory for the I-cache line-fill path;
//            critical-word-first wrapping read bursts and single-word writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_fill_ram #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int DEPTH_BYTES    = 128,
  parameter int WORDS_PER_LINE = 2,
  parameter int LATENCY        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_we,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic [((WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1)-1:0] resp_idx,
  output logic                resp_last
);

  localparam int c_BPW       = DATA_W / 8;
  localparam int c_OFF_W     = (c_BPW > 1) ? $clog2(c_BPW) : 0;
  localparam int c_NUM_WORDS = DEPTH_BYTES / c_BPW;
  localparam int c_WIDX_W    = (c_NUM_WORDS > 1) ? $clog2(c_NUM_WORDS) : 1;
  localparam int c_IDX_W     = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int c_CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [ADDR_W-1:0]  c_LINE_MASK = ADDR_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0]  c_WORD_MASK = ADDR_W'(c_NUM_WORDS - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_BEAT = c_IDX_W'(WORDS_PER_LINE - 1);
  // The accept cycle and the first beat cycle bracket the wait, so it lasts LATENCY-1 cycles.
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD  = c_CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_we;
  logic [DATA_W-1:0]    r_wdata;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_IDX_W-1:0]   r_beat;

  logic [DATA_W-1:0]    r_mem [c_NUM_WORDS];
  // Unwritten words read back their power-up pattern; the flags are never cleared by reset.
  logic [c_NUM_WORDS-1:0] r_dirty = '0;

  logic [ADDR_W-1:0]    w_word_addr;
  logic [ADDR_W-1:0]    w_line_word;
  logic [c_IDX_W-1:0]   w_start_idx;
  logic [c_IDX_W-1:0]   w_cur_idx;
  logic [c_WIDX_W-1:0]  w_mem_idx;
  logic [DATA_W-1:0]    w_rd_word;

  function automatic logic [DATA_W-1:0] f_default(input logic [c_WIDX_W-1:0] widx);
    logic [DATA_W-1:0] res;
    res = '0;
    for (int b = 0; b < c_BPW; b++) begin
      res[8*b +: 8] = 8'(int'(widx) * c_BPW + b);
    end
    return res;
  endfunction

  assign w_word_addr = r_addr >> c_OFF_W;
  assign w_line_word = w_word_addr & ~c_LINE_MASK;
  assign w_start_idx = c_IDX_W'(w_word_addr & c_LINE_MASK);
  assign w_cur_idx   = c_IDX_W'((ADDR_W'(w_start_idx) + ADDR_W'(r_beat)) & c_LINE_MASK);
  assign w_mem_idx   = c_WIDX_W'((w_line_word + ADDR_W'(w_cur_idx)) & c_WORD_MASK);
  assign w_rd_word   = r_dirty[w_mem_idx] ? r_mem[w_mem_idx] : f_default(w_mem_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_idx   = '0;
    resp_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY > 1) begin
            w_next = S_WAIT;
          end else begin
            w_next = req_we ? S_WRITE : S_BURST;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_next = r_we ? S_WRITE : S_BURST;
        end
      end
      S_BURST: begin
        resp_valid = 1'b1;
        resp_data  = w_rd_word;
        resp_idx   = w_cur_idx;
        resp_last  = (r_beat == c_LAST_BEAT);
        if (r_beat == c_LAST_BEAT) begin
          w_next = S_IDLE;
        end
      end
      S_WRITE: begin
        resp_valid = 1'b1;
        resp_data  = r_wdata;
        resp_idx   = w_cur_idx;
        resp_last  = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_we    <= req_we;
            r_wdata <= req_wdata;
            r_cnt   <= c_CNT_LOAD;
            r_beat  <= '0;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
        S_BURST: r_beat <= r_beat + c_IDX_W'(1);
        default: ;
      endcase
    end
  end

  // Gated on rst as well so a reset coinciding with the WRITE edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_WRITE)) begin
      r_mem[w_mem_idx]   <= r_wdata;
      r_dirty[w_mem_idx] <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_line_fill_ram.sv
// ============================================================================
// Module   : tb_line_fill_ram
// Purpose  : Scoreboard bench for line_fill_ram (default and LATENCY=1/4-beat build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_fill_ram;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst;
  int          cyc;
  int          checks;
  int          errors;

  logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_last;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_data;
  logic [0:0]  a_resp_idx;
  logic        v_req_valid, v_req_ready, v_req_we, v_resp_valid, v_resp_last;
  logic [31:0] v_req_addr, v_req_wdata, v_resp_data;
  logic [1:0]  v_resp_idx;

  beat_t sb_a[$];
  beat_t sb_v[$];
  beat_t ea, ev;

  line_fill_ram u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .req_we(a_req_we), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_data(a_resp_data),
    .resp_idx(a_resp_idx), .resp_last(a_resp_last)
  );

  line_fill_ram #(.LATENCY(1), .WORDS_PER_LINE(4)) u_dut_v (
    .clk(clk), .rst(rst),
    .req_valid(v_req_valid), .req_ready(v_req_ready), .req_addr(v_req_addr),
    .req_we(v_req_we), .req_wdata(v_req_wdata),
    .resp_valid(v_resp_valid), .resp_data(v_resp_data),
    .resp_idx(v_resp_idx), .resp_last(v_resp_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitors: every beat must match the head of its queue, idle outputs must be zero.
  always @(negedge clk) begin
    checks++;
    if (a_resp_valid) begin
      if (sb_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_beat cyc=%0d data=%h idx=%0d last=%0d, required no beat",
                 cyc, a_resp_data, a_resp_idx, a_resp_last);
      end else begin
        ea = sb_a.pop_front();
        if (cyc !== ea.cyc || a_resp_data !== ea.data || {1'b0, a_resp_idx} !== ea.idx ||
            a_resp_last !== ea.last) begin
          errors++;
          $display("FAIL a_beat got cyc=%0d data=%h idx=%0d last=%0d, required cyc=%0d data=%h idx=%0d last=%0d",
                   cyc, a_resp_data, a_resp_idx, a_resp_last, ea.cyc, ea.data, ea.idx, ea.last);
        end
      end
    end else if (a_resp_data !== '0 || a_resp_idx !== '0 || a_resp_last !== 1'b0) begin
      errors++;
      $display("FAIL a_idle_outputs got data=%h idx=%0d last=%0d, required all 0",
               a_resp_data, a_resp_idx, a_resp_last);
    end
  end

  always @(negedge clk) begin
    checks++;
    if (v_resp_valid) begin
      if (sb_v.size() == 0) begin
        errors++;
        $display("FAIL v_unexpected_beat cyc=%0d data=%h idx=%0d last=%0d, required no beat",
                 cyc, v_resp_data, v_resp_idx, v_resp_last);
      end else begin
        ev = sb_v.pop_front();
        if (cyc !== ev.cyc || v_resp_data !== ev.data || v_resp_idx !== ev.idx ||
            v_resp_last !== ev.last) begin
          errors++;
          $display("FAIL v_beat got cyc=%0d data=%h idx=%0d last=%0d, required cyc=%0d data=%h idx=%0d last=%0d",
                   cyc, v_resp_data, v_resp_idx, v_resp_last, ev.cyc, ev.data, ev.idx, ev.last);
        end
      end
    end else if (v_resp_data !== '0 || v_resp_idx !== '0 || v_resp_last !== 1'b0) begin
      errors++;
      $display("FAIL v_idle_outputs got data=%h idx=%0d last=%0d, required all 0",
               v_resp_data, v_resp_idx, v_resp_last);
    end
  end

  // Present a request on DUT A in the current (negedge-aligned) cycle; t0 names that cycle.
  task automatic req_a(input logic [31:0] addr, input logic we, input logic [31:0] wd, output int t0);
    a_req_valid = 1'b1; a_req_addr = addr; a_req_we = we; a_req_wdata = wd;
    t0 = cyc;
  endtask

  task automatic req_v(input logic [31:0] addr, input logic we, input logic [31:0] wd, output int t0);
    v_req_valid = 1'b1; v_req_addr = addr; v_req_we = we; v_req_wdata = wd;
    t0 = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_addr = '0; a_req_we = 1'b0; a_req_wdata = '0;
    v_req_valid = 1'b0; v_req_addr = '0; v_req_we = 1'b0; v_req_wdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0 || a_resp_data !== '0 ||
        a_resp_idx !== '0 || a_resp_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_a got ready=%0d valid=%0d data=%h idx=%0d last=%0d, required 1 0 0 0 0",
               a_req_ready, a_resp_valid, a_resp_data, a_resp_idx, a_resp_last);
    end
    checks++;
    if (v_req_ready !== 1'b1 || v_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_v got ready=%0d valid=%0d, required 1 0", v_req_ready, v_resp_valid);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Waits until cycle t0+k and verifies the block is idle with nothing outstanding.
  task automatic test_done_a(input string name, input int t0, input int k);
    while (cyc < t0 + k) @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b1 || sb_a.size() != 0) begin
      errors++;
      $display("FAIL %s_end got ready=%0d pending=%0d, required ready=1 pending=0",
               name, a_req_ready, sb_a.size());
      sb_a.delete();
    end
  endtask

  task automatic test_aligned_read();
    int t0;
    checks++;
    if (a_req_ready !== 1'b1) begin
      errors++; $display("FAIL aligned_ready got %0d required 1", a_req_ready);
    end
    req_a(32'h08, 1'b0, '0, t0);
    sb_a.push_back('{t0 + 4, 32'h0B0A0908, 2'd0, 1'b0});
    sb_a.push_back('{t0 + 5, 32'h0F0E0D0C, 2'd1, 1'b1});
    @(negedge clk);
    a_req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (a_req_ready !== 1'b0) begin
        errors++; $display("FAIL aligned_busy cyc+%0d got ready=%0d required 0", k, a_req_ready);
      end
      @(negedge clk);
    end
    test_done_a("aligned", t0, 6);
  endtask

  task automatic test_critical_word();
    int t0;
    req_a(32'h0C, 1'b0, '0, t0);
    sb_a.push_back('{t0 + 4, 32'h0F0E0D0C, 2'd1, 1'b0});
    sb_a.push_back('{t0 + 5, 32'h0B0A0908, 2'd0, 1'b1});
    @(negedge clk);
    a_req_valid = 1'b0;
    test_done_a("critical", t0, 6);
  endtask

  task automatic test_write_read();
    int t0;
    req_a(32'h10, 1'b1, 32'hDEADBEEF, t0);
    sb_a.push_back('{t0 + 4, 32'hDEADBEEF, 2'd0, 1'b1});
    @(negedge clk);
    a_req_valid = 1'b0;
    test_done_a("write", t0, 5);
    req_a(32'h10, 1'b0, '0, t0);
    sb_a.push_back('{t0 + 4, 32'hDEADBEEF, 2'd0, 1'b0});
    sb_a.push_back('{t0 + 5, 32'h17161514, 2'd1, 1'b1});
    @(negedge clk);
    a_req_valid = 1'b0;
    test_done_a("readback", t0, 6);
  endtask

  task automatic test_back_to_back();
    int t0;
    req_a(32'h88, 1'b0, '0, t0);
    sb_a.push_back('{t0 + 4, 32'h0B0A0908, 2'd0, 1'b0});
    sb_a.push_back('{t0 + 5, 32'h0F0E0D0C, 2'd1, 1'b1});
    @(negedge clk);
    a_req_addr = 32'h0C;
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (a_req_ready !== 1'b0) begin
        errors++; $display("FAIL b2b_early_accept cyc+%0d got ready=%0d required 0", k, a_req_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (a_req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_second_accept cyc+6 got ready=%0d required 1", a_req_ready);
    end
    sb_a.push_back('{t0 + 10, 32'h0F0E0D0C, 2'd1, 1'b0});
    sb_a.push_back('{t0 + 11, 32'h0B0A0908, 2'd0, 1'b1});
    @(negedge clk);
    a_req_valid = 1'b0;
    checks++;
    if (a_req_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_after_accept cyc+7 got ready=%0d required 0", a_req_ready);
    end
    test_done_a("b2b", t0, 12);
  endtask

  task automatic test_reset_mid_write();
    int t0;
    req_a(32'h20, 1'b1, 32'h12345678, t0);
    @(negedge clk);
    a_req_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got ready=%0d valid=%0d, required 1 0", a_req_ready, a_resp_valid);
    end
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (a_req_ready !== 1'b1) begin
        errors++; $display("FAIL rst_hold cyc+%0d got ready=%0d required 1", k, a_req_ready);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    req_a(32'h20, 1'b0, '0, t0);
    sb_a.push_back('{t0 + 4, 32'h23222120, 2'd0, 1'b0});
    sb_a.push_back('{t0 + 5, 32'h27262524, 2'd1, 1'b1});
    @(negedge clk);
    a_req_valid = 1'b0;
    test_done_a("rst_read", t0, 6);
  endtask

  task automatic test_variant();
    int t0;
    req_v(32'h34, 1'b0, '0, t0);
    sb_v.push_back('{t0 + 1, 32'h37363534, 2'd1, 1'b0});
    sb_v.push_back('{t0 + 2, 32'h3B3A3938, 2'd2, 1'b0});
    sb_v.push_back('{t0 + 3, 32'h3F3E3D3C, 2'd3, 1'b0});
    sb_v.push_back('{t0 + 4, 32'h33323130, 2'd0, 1'b1});
    @(negedge clk);
    v_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (v_req_ready !== 1'b1 || sb_v.size() != 0) begin
      errors++;
      $display("FAIL var_read_end got ready=%0d pending=%0d, required 1 0", v_req_ready, sb_v.size());
      sb_v.delete();
    end
    req_v(32'h38, 1'b1, 32'hA5A5A5A5, t0);
    sb_v.push_back('{t0 + 1, 32'hA5A5A5A5, 2'd2, 1'b1});
    @(negedge clk);
    v_req_valid = 1'b0;
    checks++;
    if (v_req_ready !== 1'b0) begin
      errors++; $display("FAIL var_write_busy got ready=%0d required 0", v_req_ready);
    end
    @(negedge clk);
    req_v(32'h30, 1'b0, '0, t0);
    sb_v.push_back('{t0 + 1, 32'h33323130, 2'd0, 1'b0});
    sb_v.push_back('{t0 + 2, 32'h37363534, 2'd1, 1'b0});
    sb_v.push_back('{t0 + 3, 32'hA5A5A5A5, 2'd2, 1'b0});
    sb_v.push_back('{t0 + 4, 32'h3F3E3D3C, 2'd3, 1'b1});
    @(negedge clk);
    v_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (v_req_ready !== 1'b1 || sb_v.size() != 0) begin
      errors++;
      $display("FAIL var_rmw_end got ready=%0d pending=%0d, required 1 0", v_req_ready, sb_v.size());
      sb_v.delete();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_aligned_read();
    test_critical_word();
    test_write_read();
    test_back_to_back();
    test_reset_mid_write();
    test_variant();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout at cyc=%0d", cyc);
    $fatal(1, "bench timed out");
  end

endmodule

`default_nettype wire

// File: doc/line_fill_ram.md
Name: line_fill_ram

Overview:
- Parametrised byte-addressed backing memory for the instruction cache line-fill path.
- Accepts one request at a time over a valid/ready handshake.
- After a programmable latency it either returns a whole cache line as a critical-word-first wrapping burst, or performs a single-word write.
- Sits between the cache controller and the memory model, and is synthesisable.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 32, request address width (byte address).
- DEPTH_BYTES, 128, storage size in bytes; must be a power of two.
- WORDS_PER_LINE, 2, beats per read burst; must be a power of two, at least 1.
- LATENCY, 4, cycles from request accept to first response beat; must be at least 1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  ADDR_W  byte address of the request.
- req_we  in  1  1 = single-word write, 0 = line read.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  response beat valid.
- resp_data  out  DATA_W  read data, or echoed write data.
- resp_idx  out  log2(WORDS_PER_LINE) (min 1)  word index of this beat within the line.
- resp_last  out  1  final beat of the response.

Behaviour:
- Storage and addressing
  - Byte array of DEPTH_BYTES entries. Power-up contents: byte i = i[7:0].
  - Reset does not alter contents.
  - Words are little-endian: byte at the word address is bits [7:0].
  - Address low bits below log2(DATA_W/8) are ignored (word aligned).
  - Addresses wrap modulo DEPTH_BYTES.
  - start_idx = word-in-line field of req_addr. The line base is req_addr with the word and byte offset bits cleared.
- States: IDLE, WAIT, BURST, WRITE.
- IDLE
  - req_ready = 1.
  - On req_valid & req_ready: capture addr, we and wdata; load latency counter; go to WAIT.
- WAIT
  - req_ready = 0; req_valid is ignored.
  - Counter counts down so that the first resp_valid is asserted exactly LATENCY cycles after the accept edge.
  - Exit to BURST if we=0, or WRITE if we=1.
- BURST
  - WORDS_PER_LINE consecutive beats, one per cycle, with no gaps.
  - Beat k: resp_idx = (start_idx + k) mod WORDS_PER_LINE; resp_data = word at line base + resp_idx.
  - resp_last = 1 on beat WORDS_PER_LINE-1 only.
  - The cycle after the last beat: IDLE, req_ready = 1.
- WRITE
  - Single cycle: the word is written on this edge.
  - Pulses resp_valid=1, resp_last=1, resp_idx=start_idx, resp_data=captured wdata.
  - Next cycle: IDLE.
- Back-to-back requests: a new request is accepted the first IDLE cycle after the previous response.
  - Minimum request period = LATENCY + WORDS_PER_LINE cycles for a read, LATENCY + 1 for a write.
- No response backpressure: the consumer must take every beat.
- Read of a word written by an earlier request returns the new data.
- When resp_valid = 0: resp_data, resp_idx and resp_last are all held at 0.
- Reset, at any time including mid-WAIT, BURST or WRITE:
  - Aborts the operation immediately; state returns to IDLE.
  - A write that has not yet reached its WRITE edge is never performed.
- Reset values:
  - req_ready = 1 (combinational from the IDLE state).
  - resp_valid = 0, resp_data = 0, resp_idx = 0, resp_last = 0.
  - Latency counter = 0, captured request registers = 0.

Test Plan:
- Defaults apply to all scenarios except scenario 6.
- 1. Aligned read: read 0x08 accepted at cycle 0.
  - Cycle 4: resp_valid, 0x0B0A0908, idx 0, last 0.
  - Cycle 5: 0x0F0E0D0C, idx 1, last 1.
  - Cycle 6: req_ready = 1.
- 2. Critical word first: read 0x0C.
  - Cycle 4: 0x0F0E0D0C, idx 1.
  - Cycle 5: 0x0B0A0908, idx 0, last 1.
- 3. Write then read: write 0xDEADBEEF to 0x10.
  - Cycle 4: single resp_valid pulse, resp_last = 1, data echoed.
  - Following read of 0x10 returns 0xDEADBEEF, then 0x17161514.
- 4. Address wrap and busy handling:
  - Read 0x88 returns the same beats as 0x08.
  - req_valid held high throughout: the second request is accepted at cycle 6, not earlier.
- 5. Reset mid-write: write 0x12345678 to 0x20, rst asserted at cycle 2 (asynchronous, mid-cycle).
  - resp_valid never rises; req_ready = 1 during reset.
  - A later read of 0x20 returns 0x23222120.
- 6. Parameter variant: LATENCY=1, WORDS_PER_LINE=4, read 0x34 accepted at cycle 0.
  - Beats at cycles 1-4 with idx 1, 2, 3, 0.
  - Data 0x37363534, 0x3B3A3938, 0x3F3E3D3C, 0x33323130; last on cycle 4.
